tetris_frame_packer: RTL and testbench



---
 rtl/tetris_pkg.sv | 25 ++
 rtl/tetris_frame_packer_if.sv | 12 +
 rtl/tetris_frame_fifo.sv | 53 +++++
 rtl/tetris_frame_packer.sv | 151 +++++++++++++++
 tb/tb_tetris_frame_packer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// Shared types for the TETRIS result frame packer: FSM states, frame-entry
// layout and the header byte encoding.
package tetris_pkg;

   typedef enum logic [1:0] {IDLE, HDR, BODY, DONE} state_t;

   localparam int HDR_SYNC_BIT = 7;
   localparam int BOARD_BYTES  = 9;
   localparam int BOARD_W      = 72;

   typedef struct packed {
      logic               fail;
      logic               has_board;
      logic [3:0]         score;
      logic [BOARD_W-1:0] board;
   } frame_t;

   function automatic logic [7:0] make_header(frame_t f);
      logic [7:0] h;
      h = {1'b0, f.fail, f.has_board, 1'b0, f.score};
      h[HDR_SYNC_BIT] = 1'b1;
      return h;
   endfunction

endpackage

// File: rtl/tetris_frame_packer_if.sv
// Byte-stream valid/ready link from the frame packer to the capture/logger side.
interface tetris_frame_packer_if;

   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;

   modport master (output out_valid, output out_data, output out_last, input out_ready);
   modport slave  (input out_valid, input out_data, input out_last, output out_ready);

endinterface

// File: rtl/tetris_frame_fifo.sv
// Small synchronous FIFO of frame entries; a push into a full FIFO is accepted
// when a pop happens on the same cycle.
module tetris_frame_fifo
   import tetris_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  logic   pop,
   input  frame_t wdata,
   output frame_t rdata,
   output logic   full,
   output logic   empty
);

   localparam int AW = $clog2(DEPTH);

   frame_t        mem_q [DEPTH];
   logic [AW-1:0] wptr_q;
   logic [AW-1:0] rptr_q;
   logic [AW:0]   cnt_q;
   logic          do_push;
   logic          do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem_q[rptr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata;
   end

endmodule

// File: rtl/tetris_frame_packer.sv
// Captures TETRIS core result pulses into a frame FIFO and serialises each
// frame as a header byte plus optional 9 board bytes on a valid/ready stream.
module tetris_frame_packer
   import tetris_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  score_valid,
   input  logic                  tetris_valid,
   input  logic                  fail,
   input  logic [3:0]            score,
   input  logic [BOARD_W-1:0]    tetris,
   tetris_frame_packer_if.master strm,
   output logic                  ovf,
   output logic [CNT_W-1:0]      frame_cnt
);

   frame_t             wr_entry;
   frame_t             head;
   logic               fifo_full;
   logic               fifo_empty;
   logic               pop;
   logic               xfer;

   state_t             state_q, state_d;
   logic               has_board_q, has_board_d;
   logic [BOARD_W-1:0] board_q, board_d;
   logic [3:0]         idx_q, idx_d;
   logic               out_valid_q, out_valid_d;
   logic               out_last_q, out_last_d;
   logic [7:0]         out_data_q, out_data_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q;

   always_comb begin
      wr_entry.fail      = fail;
      wr_entry.has_board = tetris_valid;
      wr_entry.score     = score;
      wr_entry.board     = tetris_valid ? tetris : '0;
   end

   tetris_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (score_valid),
      .pop   (pop),
      .wdata (wr_entry),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign xfer = out_valid_q && strm.out_ready;

   // Next-state and registered-output values; the board shifts right one byte per handshake.
   always_comb begin
      state_d     = state_q;
      has_board_d = has_board_q;
      board_d     = board_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      cnt_d       = cnt_q;
      pop         = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop         = 1'b1;
               has_board_d = head.has_board;
               board_d     = head.board;
               out_valid_d = 1'b1;
               out_data_d  = make_header(head);
               out_last_d  = !head.has_board;
               state_d     = HDR;
            end
         end
         HDR: begin
            if (xfer) begin
               if (has_board_q) begin
                  idx_d      = '0;
                  out_data_d = board_q[7:0];
                  board_d    = board_q >> 8;
                  out_last_d = 1'b0;
                  state_d    = BODY;
               end else begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  out_data_d  = '0;
                  state_d     = DONE;
               end
            end
         end
         BODY: begin
            if (xfer) begin
               if (idx_q == 4'(BOARD_BYTES-1)) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  out_data_d  = '0;
                  state_d     = DONE;
               end else begin
                  idx_d      = idx_q + 1'b1;
                  out_data_d = board_q[7:0];
                  board_d    = board_q >> 8;
                  out_last_d = (idx_q == 4'(BOARD_BYTES-2));
               end
            end
         end
         DONE: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         cnt_q       <= cnt_d;
         if (score_valid && fifo_full && !pop) ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      has_board_q <= has_board_d;
      board_q     <= board_d;
   end

   assign strm.out_valid = out_valid_q;
   assign strm.out_last  = out_last_q;
   assign strm.out_data  = out_data_q;
   assign ovf            = ovf_q;
   assign frame_cnt      = cnt_q;

endmodule

// File: tb/tb_tetris_frame_packer.sv
// Scoreboard bench for tetris_frame_packer: stimulus pushes expected bytes,
// an independent monitor pops and compares on every stream handshake.
module tb_tetris_frame_packer;
   import tetris_pkg::*;

   localparam int DEPTH = 2;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             score_valid = 1'b0;
   logic             tetris_valid = 1'b0;
   logic             fail = 1'b0;
   logic [3:0]       score = '0;
   logic [71:0]      tetris = '0;
   logic             ovf;
   logic [CNT_W-1:0] frame_cnt;

   tetris_frame_packer_if bus();

   tetris_frame_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .score_valid  (score_valid),
      .tetris_valid (tetris_valid),
      .fail         (fail),
      .score        (score),
      .tetris       (tetris),
      .strm         (bus),
      .ovf          (ovf),
      .frame_cnt    (frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } beat_t;

   beat_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    bytes_seen = 0;
   int    exp_cnt = 0;

   localparam logic [71:0] BOARD_A = 72'h0123456789ABCDEF01;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference frame: header {sync, fail, has_board, 0, score}, then board bytes LSB first.
   task automatic push_frame(logic f, logic hb, logic [3:0] sc, logic [71:0] bd);
      beat_t b;
      b.data = {1'b1, f, hb, 1'b0, sc};
      b.last = !hb;
      exp_q.push_back(b);
      if (hb) begin
         for (int i = 0; i < BOARD_BYTES; i++) begin
            b.data = bd[8*i +: 8];
            b.last = (i == BOARD_BYTES-1);
            exp_q.push_back(b);
         end
      end
   endtask

   function automatic int pending_frames();
      int n = 0;
      foreach (exp_q[i]) if (exp_q[i].last) n++;
      return n;
   endfunction

   task automatic pulse(logic f, logic tv, logic [3:0] sc, logic [71:0] bd, bit accept);
      score_valid  = 1'b1;
      tetris_valid = tv;
      fail         = f;
      score        = sc;
      tetris       = bd;
      if (accept) push_frame(f, tv, sc, bd);
      @(posedge clk); #1;
      score_valid  = 1'b0;
      tetris_valid = 1'b0;
   endtask

   task automatic drain(string name);
      int t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk(name, exp_q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic wait_bytes(int n);
      int t = 0;
      while (bytes_seen < n && t < 2000) begin
         @(posedge clk);
         t++;
      end
      chk("wait_bytes_timeout", 32'(t < 2000), 1);
   endtask

   function automatic logic [71:0] rand_board();
      return {8'($urandom()), $urandom(), $urandom()};
   endfunction

   // Monitor: compares each handshaken byte and checks hold-stability under back-pressure.
   initial begin
      beat_t b;
      logic  prev_stall = 1'b0;
      logic [7:0] prev_data = '0;
      logic  prev_last = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("hold_valid", 32'(bus.out_valid), 1);
               chk("hold_data", 32'(bus.out_data), 32'(prev_data));
               chk("hold_last", 32'(bus.out_last), 32'(prev_last));
            end
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_byte: got %0h expected no byte at %0t", bus.out_data, $time);
               end else begin
                  b = exp_q.pop_front();
                  chk("byte", 32'(bus.out_data), 32'(b.data));
                  chk("last", 32'(bus.out_last), 32'(b.last));
                  if (b.last) exp_cnt++;
               end
               bytes_seen++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_last", 32'(bus.out_last), 0);
      chk("rst_out_data", 32'(bus.out_data), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_frame_cnt", 32'(frame_cnt), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Single board frame with latency check
      bus.out_ready = 1'b1;
      pulse(1'b0, 1'b1, 4'd5, BOARD_A, 1'b1);
      chk("latency_n1_valid", 32'(bus.out_valid), 0);
      @(posedge clk); #1;
      chk("latency_n2_valid", 32'(bus.out_valid), 1);
      chk("latency_n2_hdr", 32'(bus.out_data), 32'h0A5);
      drain("drain_board");
      chk("frame_cnt_one", 32'(frame_cnt), 1);
      chk("frame_cnt_model", 32'(frame_cnt), 32'(CNT_W'(exp_cnt)));

      // Header-only frame, random board ignored
      pulse(1'b1, 1'b0, 4'd3, rand_board(), 1'b1);
      drain("drain_hdr_only");
      chk("frame_cnt_hdr", 32'(frame_cnt), 32'(CNT_W'(exp_cnt)));

      // Back-pressure in the middle of the body
      base = bytes_seen;
      pulse(1'b0, 1'b1, 4'd5, BOARD_A, 1'b1);
      wait_bytes(base + 4);
      #1;
      bus.out_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", 32'(bus.out_valid), 1);
         chk("bp_data", 32'(bus.out_data), 32'h0AB);
         chk("bp_last", 32'(bus.out_last), 0);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      drain("drain_bp");
      chk("bp_total_bytes", 32'(bytes_seen - base), 10);

      // Full FIFO with a same-cycle pop: nothing may be dropped
      pulse(1'b0, 1'b0, 4'd1, rand_board(), 1'b1);
      pulse(1'b1, 1'b1, 4'd2, rand_board(), 1'b1);
      pulse(1'b0, 1'b0, 4'd4, rand_board(), 1'b1);
      @(posedge clk); #1;
      pulse(1'b1, 1'b0, 4'd6, rand_board(), 1'b1);
      chk("fullpop_ovf", 32'(ovf), 0);
      drain("drain_fullpop");
      chk("fullpop_ovf_after", 32'(ovf), 0);
      chk("fullpop_frame_cnt", 32'(frame_cnt), 32'(CNT_W'(exp_cnt)));

      // Overflow: fourth back-to-back event is dropped
      bus.out_ready = 1'b0;
      pulse(1'b0, 1'b1, 4'd7, rand_board(), 1'b1);
      pulse(1'b1, 1'b0, 4'd8, rand_board(), 1'b1);
      pulse(1'b0, 1'b1, 4'd9, rand_board(), 1'b1);
      pulse(1'b1, 1'b1, 4'd10, rand_board(), 1'b0);
      chk("ovf_set", 32'(ovf), 1);
      bus.out_ready = 1'b1;
      drain("drain_ovf");
      chk("ovf_sticky", 32'(ovf), 1);
      chk("ovf_frame_cnt", 32'(frame_cnt), 32'(CNT_W'(exp_cnt)));

      // Reset in the middle of the body
      base = bytes_seen;
      pulse(1'b0, 1'b1, 4'd11, rand_board(), 1'b1);
      wait_bytes(base + 4);
      #1;
      rst = 1'b1;
      exp_q.delete();
      exp_cnt = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_valid", 32'(bus.out_valid), 0);
      chk("midrst_last", 32'(bus.out_last), 0);
      chk("midrst_frame_cnt", 32'(frame_cnt), 0);
      chk("midrst_ovf", 32'(ovf), 0);
      repeat (4) @(posedge clk);
      #1;
      pulse(1'b1, 1'b1, 4'd12, rand_board(), 1'b1);
      drain("drain_post_rst");
      chk("post_rst_frame_cnt", 32'(frame_cnt), 1);

      // Randomised traffic with random back-pressure and stray board strobes
      for (int it = 0; it < 800; it++) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if (pending_frames() < DEPTH && $urandom_range(0, 3) == 0) begin
            pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), rand_board(), 1'b1);
         end else if ($urandom_range(0, 7) == 0) begin
            tetris_valid = 1'b1;
            tetris       = rand_board();
            @(posedge clk); #1;
            tetris_valid = 1'b0;
         end else begin
            @(posedge clk); #1;
         end
      end
      bus.out_ready = 1'b1;
      drain("drain_random");
      chk("random_frame_cnt", 32'(frame_cnt), 32'(CNT_W'(exp_cnt)));
      chk("random_ovf", 32'(ovf), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
